// File: rtl/load_ext_pipe.sv
// Load-data extension for the memory-to-writeback path: sign/zero extension,
// lwl/lwr merges and misalignment flagging, followed by a 2-entry in-order skid buffer.
module load_ext_pipe #(
  parameter int DATA_W = 32,
  parameter int TAG_W = 5,
  parameter int CNT_W = 16,
  localparam int ADDR_W = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_din,
  input  logic [DATA_W-1:0] in_old,
  input  logic [3:0]        in_econ,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_dout,
  output logic              out_err,
  output logic [TAG_W-1:0]  out_tag,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              err_cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Widen the low n bits of v to DATA_W, filling the upper bits with ones when neg is set.
  function automatic logic [DATA_W-1:0] ext_val(input logic [31:0] v, input logic [5:0] n,
                                                input logic neg);
    logic [DATA_W-1:0] hi_mask;
    logic [DATA_W-1:0] lo;
    hi_mask = {DATA_W{1'b1}} << n;
    lo      = DATA_W'(v) & ~hi_mask;
    ext_val = neg ? (lo | hi_mask) : lo;
  endfunction

  function automatic logic [31:0] merge_lwl(input logic [31:0] w, input logic [31:0] o,
                                            input logic [1:0] b);
    logic [4:0] sh;
    sh = {~b, 3'b000};
    merge_lwl = (w << sh) | (o & ((32'd1 << sh) - 32'd1));
  endfunction

  function automatic logic [31:0] merge_lwr(input logic [31:0] w, input logic [31:0] o,
                                            input logic [1:0] b);
    logic [4:0] sh;
    sh = {b, 3'b000};
    merge_lwr = (w >> sh) | (o & ~(32'hFFFF_FFFF >> sh));
  endfunction

  logic [31:0]       sh_lo;
  logic              lane_hi;
  logic [31:0]       lane;
  logic [31:0]       old_lo;
  logic [31:0]       merged;
  logic [DATA_W-1:0] ext_dout;
  logic              ext_bad;
  logic              push;
  logic              pop;

  // Stage p0: combinational extension of the presented load
  assign sh_lo   = 32'(in_din >> {in_addr, 3'b000});
  assign lane_hi = (DATA_W == 64) ? in_addr[ADDR_W-1] : 1'b0;
  assign lane    = 32'(in_din >> {lane_hi, 5'b00000});
  assign old_lo  = 32'(in_old);

  always_comb begin
    ext_dout = '0;
    ext_bad  = 1'b0;
    merged   = '0;
    case (in_econ)
      4'd0: begin
        ext_bad  = (in_addr != '0);
        ext_dout = in_din;
      end
      4'd1: ext_dout = ext_val({24'd0, sh_lo[7:0]}, 6'd8, 1'b0);
      4'd2: ext_dout = ext_val({24'd0, sh_lo[7:0]}, 6'd8, sh_lo[7]);
      4'd3: begin
        ext_bad  = in_addr[0];
        ext_dout = ext_val({16'd0, sh_lo[15:0]}, 6'd16, 1'b0);
      end
      4'd4: begin
        ext_bad  = in_addr[0];
        ext_dout = ext_val({16'd0, sh_lo[15:0]}, 6'd16, sh_lo[15]);
      end
      // At 32 bits the address is already word-granular, so these match code 0.
      4'd5: begin
        ext_bad  = (in_addr[1:0] != 2'd0);
        ext_dout = ext_val(sh_lo, 6'd32, 1'b0);
      end
      4'd6: begin
        ext_bad  = (in_addr[1:0] != 2'd0);
        ext_dout = ext_val(sh_lo, 6'd32, sh_lo[31]);
      end
      4'd7: begin
        merged   = merge_lwl(lane, old_lo, in_addr[1:0]);
        ext_dout = ext_val(merged, 6'd32, merged[31]);
      end
      4'd8: begin
        merged   = merge_lwr(lane, old_lo, in_addr[1:0]);
        ext_dout = ext_val(merged, 6'd32, merged[31]);
      end
      default: ext_bad = 1'b1;
    endcase
    if (ext_bad) ext_dout = '0;
  end

  logic [DATA_W-1:0] dout_p1 [2];
  logic              err_p1  [2];
  logic [TAG_W-1:0]  tag_p1  [2];
  logic [1:0]        count;
  logic              rd_ptr;
  logic              wr_ptr;
  logic              vld_p1;

  assign vld_p1    = (count != 2'd0);
  assign in_ready  = (count != 2'd2);
  assign out_valid = vld_p1;
  assign push      = in_valid & in_ready;
  assign pop       = vld_p1 & out_ready;

  // Stage p1: two-entry FIFO; outputs always reflect the head entry
  always_ff @(posedge clk) begin
    if (reset) begin
      count  <= 2'd0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        dout_p1[i] <= '0;
        err_p1[i]  <= 1'b0;
        tag_p1[i]  <= '0;
      end
    end else begin
      if (push) begin
        dout_p1[wr_ptr] <= ext_dout;
        err_p1[wr_ptr]  <= ext_bad;
        tag_p1[wr_ptr]  <= in_tag;
        wr_ptr          <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign out_dout = dout_p1[rd_ptr];
  assign out_err  = err_p1[rd_ptr];
  assign out_tag  = tag_p1[rd_ptr];

  // Clear wins over a coincident errored push.
  always_ff @(posedge clk) begin
    if (reset || err_cnt_clr) begin
      err_cnt <= '0;
    end else if (push && ext_bad && (err_cnt != CNT_MAX)) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_load_ext_pipe.sv
// Scoreboard bench: a 32-bit and a 64-bit instance share stimulus; expected results
// come from a behavioural model of the load rules and are queued per instance.
module tb_load_ext_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, in_valid, out_ready, err_cnt_clr;
  logic [2:0]  addr;
  logic [63:0] din, old;
  logic [3:0]  econ;
  logic [4:0]  tag;

  logic        rdy32, vld32, err32;
  logic [31:0] dout32;
  logic [4:0]  tag32;
  logic [15:0] cnt32;
  logic        rdy64, vld64, err64;
  logic [63:0] dout64;
  logic [4:0]  tag64;
  logic [2:0]  cnt64;

  load_ext_pipe #(.DATA_W(32), .TAG_W(5), .CNT_W(16)) dut32 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy32),
    .in_addr(addr[1:0]), .in_din(din[31:0]), .in_old(old[31:0]), .in_econ(econ),
    .in_tag(tag), .out_valid(vld32), .out_ready(out_ready), .out_dout(dout32),
    .out_err(err32), .out_tag(tag32), .err_cnt(cnt32), .err_cnt_clr(err_cnt_clr)
  );

  load_ext_pipe #(.DATA_W(64), .TAG_W(5), .CNT_W(3)) dut64 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(rdy64),
    .in_addr(addr), .in_din(din), .in_old(old), .in_econ(econ),
    .in_tag(tag), .out_valid(vld64), .out_ready(out_ready), .out_dout(dout64),
    .out_err(err64), .out_tag(tag64), .err_cnt(cnt64), .err_cnt_clr(err_cnt_clr)
  );

  typedef struct {
    logic [63:0] d;
    logic        e;
    logic [4:0]  t;
  } exp_t;

  exp_t        q[2][$];
  int unsigned ecnt[2];
  bit          after_rst[2];
  bit          started = 1'b0;
  int          checks = 0;
  int          errors = 0;

  function automatic logic [63:0] sx(input logic [63:0] x, input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    x = x & m;
    if (((x >> (n - 1)) & 64'd1) != 64'd0) x = x | ~m;
    return x;
  endfunction

  // Returns {err, result} for a load of width w, built directly from the load rules.
  function automatic logic [64:0] model(input int w, input logic [63:0] din_i,
                                        input logic [2:0] a_i, input logic [63:0] old_i,
                                        input logic [3:0] e);
    logic [63:0] wm, d, s, lane, o, r, v;
    int a, b;
    bit bad;
    wm   = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    d    = din_i & wm;
    a    = (w == 64) ? int'(a_i) : int'(a_i) % 4;
    b    = a % 4;
    s    = d >> (8 * a);
    lane = (d >> (32 * (a / 4))) & 64'hFFFF_FFFF;
    o    = old_i & 64'hFFFF_FFFF;
    bad  = 1'b0;
    v    = 64'd0;
    case (e)
      4'd0: begin bad = (a != 0); v = d; end
      4'd1: v = s & 64'hFF;
      4'd2: v = sx(s, 8);
      4'd3: begin bad = (a % 2 != 0); v = s & 64'hFFFF; end
      4'd4: begin bad = (a % 2 != 0); v = sx(s, 16); end
      4'd5, 4'd6: begin
        if (w == 32) begin
          bad = (a != 0); v = d;
        end else begin
          bad = (a % 4 != 0);
          v   = (e == 4'd5) ? (s & 64'hFFFF_FFFF) : sx(s, 32);
        end
      end
      4'd7: begin
        r = ((lane << (8 * (3 - b))) | (o & ((64'd1 << (8 * (3 - b))) - 64'd1))) & 64'hFFFF_FFFF;
        v = sx(r, 32);
      end
      4'd8: begin
        r = ((lane >> (8 * b)) | (o & ~(64'hFFFF_FFFF >> (8 * b)))) & 64'hFFFF_FFFF;
        v = sx(r, 32);
      end
      default: bad = 1'b1;
    endcase
    v = v & wm;
    if (bad) v = 64'd0;
    return {bad, v};
  endfunction

  task automatic chk(input string nm, input int k, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s[w%0d] @%0t got=%h expected=%h", nm, (k == 0) ? 32 : 64, $time, got, exp);
    end
  endtask

  // Reference state advances on each rising edge using the pre-edge inputs and ready.
  always @(posedge clk) begin
    bit rdy_k;
    logic [64:0] m;
    int unsigned cmax;
    if (reset) begin
      q[0].delete();
      q[1].delete();
      ecnt[0] = 0;
      ecnt[1] = 0;
      after_rst[0] = 1'b1;
      after_rst[1] = 1'b1;
      started = 1'b1;
    end else if (started) begin
      for (int k = 0; k < 2; k++) begin
        rdy_k = (k == 0) ? rdy32 : rdy64;
        cmax  = (k == 0) ? 65535 : 7;
        m     = model((k == 0) ? 32 : 64, din, addr, old, econ);
        if (in_valid && rdy_k) begin
          q[k].push_back('{d: m[63:0], e: m[64], t: tag});
          after_rst[k] = 1'b0;
        end
        if (err_cnt_clr) ecnt[k] = 0;
        else if (in_valid && rdy_k && m[64] && ecnt[k] != cmax) ecnt[k]++;
      end
    end
  end

  always @(negedge clk) begin
    logic        a_v, a_r, a_e;
    logic [63:0] a_d, a_c;
    logic [4:0]  a_t;
    exp_t        h;
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        a_v = (k == 0) ? vld32 : vld64;
        a_r = (k == 0) ? rdy32 : rdy64;
        a_e = (k == 0) ? err32 : err64;
        a_d = (k == 0) ? {32'd0, dout32} : dout64;
        a_t = (k == 0) ? tag32 : tag64;
        a_c = (k == 0) ? {48'd0, cnt32} : {61'd0, cnt64};
        chk("in_ready", k, {63'd0, a_r}, {63'd0, (q[k].size() != 2)});
        chk("out_valid", k, {63'd0, a_v}, {63'd0, (q[k].size() != 0)});
        chk("err_cnt", k, a_c, 64'(ecnt[k]));
        if (a_v && q[k].size() > 0) begin
          h = q[k][0];
          chk("dout", k, a_d, h.d);
          chk("err", k, {63'd0, a_e}, {63'd0, h.e});
          chk("tag", k, {59'd0, a_t}, {59'd0, h.t});
          if (out_ready) void'(q[k].pop_front());
        end else if (!a_v && after_rst[k]) begin
          chk("reset_outputs", k, {58'd0, a_e, a_t} | a_d, 64'd0);
        end
      end
    end
  end

  task automatic drive(input bit v, input logic [2:0] a, input logic [63:0] d,
                       input logic [63:0] o, input logic [3:0] e, input bit ordy,
                       input bit clr, input bit rst);
    @(posedge clk);
    #1;
    in_valid = v; addr = a; din = d; old = o; econ = e;
    out_ready = ordy; err_cnt_clr = clr; reset = rst;
    tag = tag + 5'd1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 3'd0, 64'd0, 64'd0, 4'd0, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; err_cnt_clr = 1'b0;
    addr = '0; din = '0; old = '0; econ = '0; tag = '0;
    drive(1'b0, 3'd0, 64'd0, 64'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 3'd0, 64'd0, 64'd0, 4'd0, 1'b1, 1'b0, 1'b1);
    idle(2);

    drive(1'b1, 3'd1, 64'h8899AABB, 64'd0, 4'd2, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 64'h8899AABB, 64'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 64'h8899AABB, 64'd0, 4'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd2, 64'h8899AABB, 64'd0, 4'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 64'h11223344, 64'hAABBCCDD, 4'd7, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 64'h11223344, 64'hAABBCCDD, 4'd8, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 64'h80000001_00000000, 64'd0, 4'd6, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd4, 64'h80000001_00000000, 64'd0, 4'd0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd5, 64'h11223344_55667788, 64'hAABBCCDD, 4'd7, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd7, 64'h11223344_55667788, 64'hAABBCCDD, 4'd8, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Backpressure: third load is refused until the consumer drains.
    drive(1'b1, 3'd0, 64'h1, 64'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd0, 64'h2, 64'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd0, 64'h3, 64'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd0, 64'h4, 64'd0, 4'd1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd0, 64'h5, 64'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd0, 64'h6, 64'd0, 4'd1, 1'b1, 1'b0, 1'b0);
    idle(3);

    // Reset with a full buffer, then clear racing an errored push.
    drive(1'b1, 3'd1, 64'hAA, 64'd0, 4'd4, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd3, 64'hBB, 64'd0, 4'd3, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 3'd0, 64'hCC, 64'd0, 4'd1, 1'b0, 1'b0, 1'b1);
    idle(2);
    drive(1'b1, 3'd1, 64'hAA, 64'd0, 4'd4, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 3'd1, 64'hAA, 64'd0, 4'd4, 1'b1, 1'b1, 1'b0);
    idle(2);

    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
            {$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 59) == 0),
            ($urandom_range(0, 249) == 0));
    end
    idle(5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/load_ext_pipe.md
# load_ext_pipe

Parametrised, pipelined load-data extension unit for the CPU's memory-to-writeback path. It takes the raw aligned memory word, the low address bits and a load-type code, and produces the register-ready value: byte, half and word loads in signed and unsigned forms, full-width loads, and the little-endian unaligned merges `lwl` and `lwr`. It also detects misaligned accesses and flags them. Results pass through a 2-entry in-order buffer with valid/ready handshakes on both sides, so the writeback stage can stall without dropping loads.

## Interface
Parameters:
- `DATA_W`, 32: datapath width. Legal values are 32 and 64.
- `TAG_W`, 5: width of the destination-register tag carried alongside each load.
- `CNT_W`, 16: width of the misalignment error counter.
- Derived: `ADDR_W = log2(DATA_W/8)`, which is 2 or 3.

Ports:
- `clk` in 1: the single clock. All state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `in_valid` in 1: an input load is presented.
- `in_ready` out 1: the block can accept a load this cycle.
- `in_addr` in `ADDR_W`: low byte-address bits.
- `in_din` in `DATA_W`: raw memory word. Byte 0 is `in_din[7:0]` (little-endian).
- `in_old` in `DATA_W`: current destination register value, used only by `lwl` and `lwr`.
- `in_econ` in 4: load type (encoding under Operation).
- `in_tag` in `TAG_W`: destination tag, passed through unmodified.
- `out_valid` out 1: a result is presented.
- `out_ready` in 1: the consumer accepts the result.
- `out_dout` out `DATA_W`: extended result.
- `out_err` out 1: the access was misaligned or used a reserved code.
- `out_tag` out `TAG_W`: tag of the presented result.
- `err_cnt` out `CNT_W`: saturating count of accepted loads with `out_err` set.
- `err_cnt_clr` in 1: synchronous clear of `err_cnt`.

## Operation
- Extension is combinational at the input. The buffer stores `{dout, err, tag}`.
- Let `s = in_din >> (8*in_addr)`.
- `in_econ` encoding:
  - 0: full width (`lw` at 32, `ld` at 64), result `in_din`.
  - 1: `lbu`, zero-extend `s[7:0]`.
  - 2: `lb`, sign-extend `s[7:0]`.
  - 3: `lhu`, zero-extend `s[15:0]`.
  - 4: `lh`, sign-extend `s[15:0]`.
  - 5: `lwu`, zero-extend `s[31:0]`.
  - 6: `lw`, sign-extend `s[31:0]`.
  - 7: `lwl`.
  - 8: `lwr`.
  - At `DATA_W=32`, codes 5 and 6 behave exactly as code 0.
- `lwl` and `lwr` rules:
  - Lane `W` is `in_din[31:0]`, or at 64 the word selected by `in_addr[2]`.
  - `b = in_addr[1:0]`, `O = in_old[31:0]`.
  - `lwl`: `r = (W << 8*(3-b)) | (O & ((1 << 8*(3-b)) - 1))`.
  - `lwr`: `r = (W >> 8*b) | (O & ~(32'hFFFFFFFF >> 8*b))`.
  - At 32 the result is `r`. At 64 the result is `r` sign-extended from bit 31.
- Misalignment sets err = 1 and forces dout = 0:
  - Half loads (3, 4) with `in_addr[0] != 0`.
  - Word loads (5, 6, or 0 at 32) with `in_addr[1:0] != 0`.
  - Code 0 at 64 with `in_addr != 0`.
  - Byte loads, `lwl` and `lwr` never misalign.
- Reserved codes 9–15 set err = 1 and force dout = 0.
- Buffer: 2 entries, FIFO order. `count` is 0..2.
  - `in_ready = (count != 2)`, driven from registered state only.
  - `out_valid = (count != 0)`.
  - Outputs always show the head entry.
- Push occurs when `in_valid && in_ready`. Pop occurs when `out_valid && out_ready`. Push and pop in the same cycle leave `count` unchanged and both take effect.
- `err_cnt`:
  - Increments on a push whose entry has err = 1.
  - Saturates at `2^CNT_W - 1`.
  - `err_cnt_clr` takes priority over the increment. The counter reads 0 the cycle after clear, even if the clear coincided with an errored push.

## Timing
- Reset values:
  - `count = 0`.
  - `in_ready = 1`, `out_valid = 0`.
  - `out_dout = 0`, `out_err = 0`, `out_tag = 0`.
  - `err_cnt = 0`.
  - Entries in flight at reset are discarded. Reset mid-stream produces no output the following cycle.
- Latency: a load pushed in cycle N appears on `out_*` in cycle N+1 when the buffer was empty, or behind the older entry otherwise.
- Throughput is 1 load per cycle while `out_ready = 1`.
- When the buffer is full and `out_ready = 1`:
  - The pop happens this cycle.
  - `in_ready` is 0 this cycle and rises to 1 in the next.
- When `out_ready = 0`, the outputs hold stable until the pop.

## Test plan
- Reset, then push `in_din=32'h8899AABB`, `in_addr=1`, code 2 -> next cycle `out_dout=32'hFFFFFFAA`, `out_err=0`. Same input with code 1 -> `32'h000000AA`.
- Code 4 at `in_addr=1` -> `out_err=1`, `out_dout=0`, `err_cnt=1`. Code 4 at `in_addr=2` with `32'h8899AABB` -> `32'hFFFF8899`.
- `lwl` with `W=32'h11223344`, `O=32'hAABBCCDD`, `b=1` -> `32'h3344CCDD`. `lwr` with the same inputs, `b=1` -> `32'hAA112233`.
- `DATA_W=64`, code 6, `in_addr=4`, `in_din=64'h80000001_00000000` -> `64'hFFFFFFFF80000001`. Code 0 with `in_addr=4` -> `out_err=1`.
- Hold `out_ready=0` and push 3 loads back-to-back -> `in_ready` falls after 2 accepts. Raise `out_ready` -> tags emerge in order, with no loss and no duplicate.
- Assert `reset` while 2 entries are held -> next cycle `out_valid=0`, `in_ready=1`, `err_cnt=0`. Assert `err_cnt_clr` together with an errored push -> `err_cnt=0`.
